axi_user_arb: RTL and testbench

//  N-channel arbiter between CPU-side requesters (icache, dcache, uncached MMIO) and the single

---
 rtl/axi_user_arb_pkg.sv | 14 +
 rtl/axi_user_arb_if.sv | 41 ++++
 rtl/axi_user_arb_rr_pick.sv | 35 +++
 rtl/axi_user_arb.sv | 131 +++++++++++++
 tb/tb_axi_user_arb.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_user_arb_pkg.sv
// rtl/axi_user_arb_pkg.sv - shared types and helpers for the user-port arbiter
package axi_user_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  function automatic int wrap_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/axi_user_arb_if.sv
// rtl/axi_user_arb_if.sv - requester-side and axi_rw-side signals of the arbiter
interface axi_user_arb_if #(
  parameter int NCH    = 3,
  parameter int DATA_W = 512,
  parameter int ADDR_W = 64
);
  logic [NCH-1:0]        ch_valid_i;
  logic [NCH-1:0]        ch_op_i;
  logic [NCH*ADDR_W-1:0] ch_addr_i;
  logic [NCH*2-1:0]      ch_size_i;
  logic [NCH*8-1:0]      ch_blks_i;
  logic [NCH*DATA_W-1:0] ch_wdata_i;
  logic [NCH-1:0]        ch_ready_o;
  logic [DATA_W-1:0]     ch_rdata_o;
  logic [1:0]            ch_resp_o;
  logic [NCH-1:0]        grant_o;
  logic                  user_valid_o;
  logic                  user_op_o;
  logic [ADDR_W-1:0]     user_addr_o;
  logic [1:0]            user_size_o;
  logic [7:0]            user_blks_o;
  logic [DATA_W-1:0]     user_wdata_o;
  logic                  user_ready_i;
  logic [DATA_W-1:0]     user_rdata_i;
  logic [1:0]            user_resp_i;

  // slave: the arbiter itself
  modport slave (
    input  ch_valid_i, ch_op_i, ch_addr_i, ch_size_i, ch_blks_i, ch_wdata_i,
    input  user_ready_i, user_rdata_i, user_resp_i,
    output ch_ready_o, ch_rdata_o, ch_resp_o, grant_o,
    output user_valid_o, user_op_o, user_addr_o, user_size_o, user_blks_o, user_wdata_o
  );

  modport master (
    output ch_valid_i, ch_op_i, ch_addr_i, ch_size_i, ch_blks_i, ch_wdata_i,
    output user_ready_i, user_rdata_i, user_resp_i,
    input  ch_ready_o, ch_rdata_o, ch_resp_o, grant_o,
    input  user_valid_o, user_op_o, user_addr_o, user_size_o, user_blks_o, user_wdata_o
  );
endinterface

// File: rtl/axi_user_arb_rr_pick.sv
// rtl/axi_user_arb_rr_pick.sv - combinational winner pick, rotating or lowest-index-first
module axi_user_arb_rr_pick
  import axi_user_arb_pkg::*;
#(
  parameter int NCH   = 3,
  parameter int IDX_W = 2
) (
  input  logic [NCH-1:0]   req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             mode,
  output logic [NCH-1:0]   grant,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  int c;

  // mode=1 ignores ptr so the scan always starts at channel 0
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    c     = 0;
    for (int k = 0; k < NCH; k++) begin
      c = mode ? k : int'(ptr) + k;
      if (c >= NCH) c = c - NCH;
      if (!found && req[c]) begin
        found    = 1'b1;
        idx      = IDX_W'(c);
        grant[c] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_user_arb.sv
// rtl/axi_user_arb.sv - N-channel arbiter in front of the single axi_rw user port
module axi_user_arb
  import axi_user_arb_pkg::*;
#(
  parameter int NCH      = 3,
  parameter int DATA_W   = 512,
  parameter int ADDR_W   = 64,
  parameter int ARB_MODE = 0
) (
  input  logic          clock,
  input  logic          reset,
  axi_user_arb_if.slave bus
);

  localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;

  arb_state_e        state_q, state_d;
  logic [NCH-1:0]    grant_q, grant_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic              user_valid_q, user_valid_d;
  logic              user_op_q, user_op_d;
  logic [ADDR_W-1:0] user_addr_q, user_addr_d;
  logic [1:0]        user_size_q, user_size_d;
  logic [7:0]        user_blks_q, user_blks_d;
  logic [DATA_W-1:0] user_wdata_q, user_wdata_d;
  logic [NCH-1:0]    ch_ready_q, ch_ready_d;
  logic [DATA_W-1:0] ch_rdata_q, ch_rdata_d;
  logic [1:0]        ch_resp_q, ch_resp_d;

  logic [NCH-1:0]    pick_grant;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_found;
  int                sel;

  axi_user_arb_rr_pick #(.NCH(NCH), .IDX_W(IDX_W)) u_pick (
    .req   (bus.ch_valid_i),
    .ptr   (ptr_q),
    .mode  (ARB_MODE != 0),
    .grant (pick_grant),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    ptr_d        = ptr_q;
    user_valid_d = user_valid_q;
    user_op_d    = user_op_q;
    user_addr_d  = user_addr_q;
    user_size_d  = user_size_q;
    user_blks_d  = user_blks_q;
    user_wdata_d = user_wdata_q;
    ch_ready_d   = '0;
    ch_rdata_d   = ch_rdata_q;
    ch_resp_d    = ch_resp_q;
    sel          = int'(pick_idx);
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          user_valid_d = 1'b1;
          user_op_d    = bus.ch_op_i[pick_idx];
          user_addr_d  = bus.ch_addr_i[sel*ADDR_W +: ADDR_W];
          user_size_d  = bus.ch_size_i[sel*2 +: 2];
          user_blks_d  = bus.ch_blks_i[sel*8 +: 8];
          user_wdata_d = bus.ch_wdata_i[sel*DATA_W +: DATA_W];
          grant_d      = pick_grant;
          if (ARB_MODE == 0) ptr_d = IDX_W'(wrap_inc(sel, NCH));
          state_d      = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // requester valids are not looked at here; the owner may drop out early
        if (bus.user_ready_i) begin
          user_valid_d = 1'b0;
          ch_ready_d   = grant_q;
          ch_rdata_d   = bus.user_rdata_i;
          ch_resp_d    = bus.user_resp_i;
          state_d      = ST_RESP;
        end
      end
      ST_RESP: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      ptr_q        <= '0;
      user_valid_q <= 1'b0;
      user_op_q    <= 1'b0;
      user_addr_q  <= '0;
      user_size_q  <= '0;
      user_blks_q  <= '0;
      user_wdata_q <= '0;
      ch_ready_q   <= '0;
      ch_rdata_q   <= '0;
      ch_resp_q    <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      ptr_q        <= ptr_d;
      user_valid_q <= user_valid_d;
      user_op_q    <= user_op_d;
      user_addr_q  <= user_addr_d;
      user_size_q  <= user_size_d;
      user_blks_q  <= user_blks_d;
      user_wdata_q <= user_wdata_d;
      ch_ready_q   <= ch_ready_d;
      ch_rdata_q   <= ch_rdata_d;
      ch_resp_q    <= ch_resp_d;
    end
  end

  assign bus.grant_o      = grant_q;
  assign bus.user_valid_o = user_valid_q;
  assign bus.user_op_o    = user_op_q;
  assign bus.user_addr_o  = user_addr_q;
  assign bus.user_size_o  = user_size_q;
  assign bus.user_blks_o  = user_blks_q;
  assign bus.user_wdata_o = user_wdata_q;
  assign bus.ch_ready_o   = ch_ready_q;
  assign bus.ch_rdata_o   = ch_rdata_q;
  assign bus.ch_resp_o    = ch_resp_q;

endmodule

// File: tb/tb_axi_user_arb.sv
// tb/tb_axi_user_arb.sv - round-robin and fixed-priority arbiters driven in lockstep
module tb_axi_user_arb;

  localparam int NCH    = 3;
  localparam int DATA_W = 512;
  localparam int ADDR_W = 64;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic                  reset;
  logic [NCH-1:0]        ch_valid, ch_op;
  logic [NCH*ADDR_W-1:0] ch_addr;
  logic [NCH*2-1:0]      ch_size;
  logic [NCH*8-1:0]      ch_blks;
  logic [NCH*DATA_W-1:0] ch_wdata;
  logic                  user_ready;
  logic [DATA_W-1:0]     user_rdata;
  logic [1:0]            user_resp;

  axi_user_arb_if #(.NCH(NCH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) if_rr ();
  axi_user_arb_if #(.NCH(NCH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) if_fp ();

  assign if_rr.ch_valid_i = ch_valid;   assign if_fp.ch_valid_i = ch_valid;
  assign if_rr.ch_op_i = ch_op;         assign if_fp.ch_op_i = ch_op;
  assign if_rr.ch_addr_i = ch_addr;     assign if_fp.ch_addr_i = ch_addr;
  assign if_rr.ch_size_i = ch_size;     assign if_fp.ch_size_i = ch_size;
  assign if_rr.ch_blks_i = ch_blks;     assign if_fp.ch_blks_i = ch_blks;
  assign if_rr.ch_wdata_i = ch_wdata;   assign if_fp.ch_wdata_i = ch_wdata;
  assign if_rr.user_ready_i = user_ready; assign if_fp.user_ready_i = user_ready;
  assign if_rr.user_rdata_i = user_rdata; assign if_fp.user_rdata_i = user_rdata;
  assign if_rr.user_resp_i = user_resp;   assign if_fp.user_resp_i = user_resp;

  axi_user_arb #(.NCH(NCH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ARB_MODE(0)) dut_rr (
    .clock(clock), .reset(reset), .bus(if_rr.slave));
  axi_user_arb #(.NCH(NCH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ARB_MODE(1)) dut_fp (
    .clock(clock), .reset(reset), .bus(if_fp.slave));

  // per-instance views: index 0 = round-robin, 1 = fixed priority
  logic [NCH-1:0]    a_grant[2], a_ready[2];
  logic [DATA_W-1:0] a_rdata[2], a_wdata[2];
  logic [1:0]        a_resp[2], a_size[2];
  logic              a_uvalid[2], a_op[2];
  logic [ADDR_W-1:0] a_addr[2];
  logic [7:0]        a_blks[2];

  assign a_grant[0] = if_rr.grant_o;      assign a_grant[1] = if_fp.grant_o;
  assign a_ready[0] = if_rr.ch_ready_o;   assign a_ready[1] = if_fp.ch_ready_o;
  assign a_rdata[0] = if_rr.ch_rdata_o;   assign a_rdata[1] = if_fp.ch_rdata_o;
  assign a_resp[0]  = if_rr.ch_resp_o;    assign a_resp[1]  = if_fp.ch_resp_o;
  assign a_uvalid[0] = if_rr.user_valid_o; assign a_uvalid[1] = if_fp.user_valid_o;
  assign a_op[0]    = if_rr.user_op_o;    assign a_op[1]    = if_fp.user_op_o;
  assign a_addr[0]  = if_rr.user_addr_o;  assign a_addr[1]  = if_fp.user_addr_o;
  assign a_size[0]  = if_rr.user_size_o;  assign a_size[1]  = if_fp.user_size_o;
  assign a_blks[0]  = if_rr.user_blks_o;  assign a_blks[1]  = if_fp.user_blks_o;
  assign a_wdata[0] = if_rr.user_wdata_o; assign a_wdata[1] = if_fp.user_wdata_o;

  int checks = 0;
  int failures = 0;
  bit started = 1'b0;

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Transaction-level model: who owns the port, whether the answer is being handed back,
  // and the request/response fields last latched.
  int                m_owner[2];
  bit                m_deliver[2];
  int                m_ptr[2];
  int                mw, mc;
  logic              e_op[2];
  logic [ADDR_W-1:0] e_addr[2];
  logic [1:0]        e_size[2], e_resp[2];
  logic [7:0]        e_blks[2];
  logic [DATA_W-1:0] e_wdata[2], e_rdata[2];
  int                glog_rr[$], glog_fp[$];

  always @(posedge clock) begin
    for (int m = 0; m < 2; m++) begin
      if (!reset) begin
        m_owner[m] = -1; m_deliver[m] = 1'b0; m_ptr[m] = 0;
        e_op[m] = 1'b0; e_addr[m] = '0; e_size[m] = '0; e_blks[m] = '0;
        e_wdata[m] = '0; e_rdata[m] = '0; e_resp[m] = '0;
      end else if (m_deliver[m]) begin
        m_owner[m] = -1;
        m_deliver[m] = 1'b0;
      end else if (m_owner[m] >= 0) begin
        if (user_ready) begin
          m_deliver[m] = 1'b1;
          e_rdata[m] = user_rdata;
          e_resp[m] = user_resp;
        end
      end else begin
        mw = -1;
        for (int k = 0; k < NCH; k++) begin
          mc = (m == 1) ? k : (m_ptr[m] + k) % NCH;
          if (mw < 0 && ch_valid[mc]) mw = mc;
        end
        if (mw >= 0) begin
          m_owner[m] = mw;
          e_op[m] = ch_op[mw];
          e_addr[m] = ch_addr[mw*ADDR_W +: ADDR_W];
          e_size[m] = ch_size[mw*2 +: 2];
          e_blks[m] = ch_blks[mw*8 +: 8];
          e_wdata[m] = ch_wdata[mw*DATA_W +: DATA_W];
          m_ptr[m] = (mw + 1) % NCH;
          if (m == 0) glog_rr.push_back(mw); else glog_fp.push_back(mw);
        end
      end
    end
  end

  string iname[2] = '{"rr", "fp"};
  logic [NCH-1:0] x_grant, x_ready;

  always @(negedge clock) begin
    if (started) begin
      for (int m = 0; m < 2; m++) begin
        x_grant = (m_owner[m] >= 0) ? NCH'(1) << m_owner[m] : '0;
        x_ready = m_deliver[m] ? x_grant : '0;
        chk({iname[m], ".grant"}, a_grant[m], x_grant);
        chk({iname[m], ".ch_ready"}, a_ready[m], x_ready);
        chk({iname[m], ".user_valid"}, a_uvalid[m], (m_owner[m] >= 0) && !m_deliver[m]);
        chk({iname[m], ".user_op"}, a_op[m], e_op[m]);
        chk({iname[m], ".user_addr"}, a_addr[m], e_addr[m]);
        chk({iname[m], ".user_size"}, a_size[m], e_size[m]);
        chk({iname[m], ".user_blks"}, a_blks[m], e_blks[m]);
        chk({iname[m], ".user_wdata"}, a_wdata[m], e_wdata[m]);
        chk({iname[m], ".ch_rdata"}, a_rdata[m], e_rdata[m]);
        chk({iname[m], ".ch_resp"}, a_resp[m], e_resp[m]);
      end
    end
  end

  // Waits for the shared user_valid, then completes the transfer; returns on the
  // negedge after user_ready is dropped (hold=1: the ch_ready cycle).
  task automatic serve(input logic [DATA_W-1:0] rd, input logic [1:0] rs, input int hold);
    int n = 0;
    while (!if_rr.user_valid_o && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("serve.wait_user_valid", if_rr.user_valid_o, 1);
    user_rdata = rd;
    user_resp = rs;
    user_ready = 1'b1;
    repeat (hold) @(negedge clock);
    user_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  int rr_exp[6] = '{0, 1, 2, 0, 1, 2};
  int nlog;
  logic [DATA_W-1:0] pat;

  initial begin
    reset = 1'b0;
    ch_valid = '0; ch_op = '0; ch_addr = '0; ch_size = '0; ch_blks = '0; ch_wdata = '0;
    user_ready = 1'b0; user_rdata = '0; user_resp = '0;
    repeat (2) @(negedge clock);
    started = 1'b1;
    chk("reset.grant", if_rr.grant_o, 0);
    chk("reset.user_valid", if_rr.user_valid_o, 0);
    chk("reset.ch_ready", if_rr.ch_ready_o, 0);
    reset = 1'b1;

    // spurious completion while idle
    user_rdata = {16{32'hDEAD_BEEF}};
    user_resp = 2'b11;
    user_ready = 1'b1;
    @(negedge clock);
    user_ready = 1'b0;
    chk("idle_spurious.ch_ready", if_rr.ch_ready_o, 0);
    chk("idle_spurious.grant", if_rr.grant_o, 0);
    chk("idle_spurious.rdata_hold", if_rr.ch_rdata_o, 0);

    // single read on channel 1
    ch_addr[1*ADDR_W +: ADDR_W] = 64'h8000_0040;
    ch_blks[1*8 +: 8] = 8'd7;
    ch_size[1*2 +: 2] = 2'd3;
    ch_valid = 3'b010;
    @(negedge clock);
    chk("rd1.user_valid", if_rr.user_valid_o, 1);
    chk("rd1.user_addr", if_rr.user_addr_o, 64'h8000_0040);
    chk("rd1.user_blks", if_rr.user_blks_o, 7);
    chk("rd1.grant", if_rr.grant_o, 3'b010);
    pat = {64{8'h3C}};
    serve(pat, 2'b01, 1);
    ch_valid = '0;
    chk("rd1.ch_ready", if_rr.ch_ready_o, 3'b010);
    chk("rd1.ch_rdata", if_rr.ch_rdata_o, pat);
    chk("rd1.ch_resp", if_rr.ch_resp_o, 2'b01);
    @(negedge clock);
    chk("rd1.ch_ready_clear", if_rr.ch_ready_o, 0);

    // all three channels requesting continuously
    do_reset();
    glog_rr.delete();
    glog_fp.delete();
    for (int i = 0; i < NCH; i++) begin
      ch_addr[i*ADDR_W +: ADDR_W] = 64'h1000 * (i + 1);
      ch_blks[i*8 +: 8] = 8'(i + 1);
      ch_size[i*2 +: 2] = 2'(i);
    end
    ch_valid = 3'b111;
    for (int i = 0; i < 6; i++) serve({16{$urandom}}, 2'(i), 1);
    ch_valid = '0;
    repeat (2) @(negedge clock);
    chk("rr.grant_count", glog_rr.size(), 6);
    chk("fp.grant_count", glog_fp.size(), 6);
    for (int i = 0; i < 6 && i < glog_rr.size(); i++) chk("rr.grant_order", glog_rr[i], rr_exp[i]);
    for (int i = 0; i < 6 && i < glog_fp.size(); i++) chk("fp.grant_order", glog_fp[i], 0);

    // write on channel 2 that drops valid while the transfer is in flight
    nlog = glog_rr.size();
    ch_op = 3'b100;
    ch_wdata[2*DATA_W +: DATA_W] = {64{8'hA5}};
    ch_valid = 3'b100;
    @(negedge clock);
    ch_valid = '0;
    repeat (3) begin
      @(negedge clock);
      chk("wr2.user_valid_held", if_rr.user_valid_o, 1);
      chk("wr2.user_op", if_rr.user_op_o, 1);
      chk("wr2.user_wdata", if_rr.user_wdata_o, {64{8'hA5}});
    end
    serve('0, 2'b00, 1);
    chk("wr2.rr_ch_ready", if_rr.ch_ready_o, 3'b100);
    chk("wr2.fp_ch_ready", if_fp.ch_ready_o, 3'b100);
    repeat (4) @(negedge clock);
    chk("wr2.no_regrant", glog_rr.size(), nlog + 1);

    // reset during a transfer, then a completion pulse that nobody asked for
    ch_op = '0;
    ch_valid = 3'b010;
    @(negedge clock);
    chk("rst.busy_user_valid", if_rr.user_valid_o, 1);
    ch_valid = '0;
    reset = 1'b0;
    @(negedge clock);
    chk("rst.grant", if_rr.grant_o, 0);
    chk("rst.user_valid", if_rr.user_valid_o, 0);
    chk("rst.user_addr", if_rr.user_addr_o, 0);
    reset = 1'b1;
    user_ready = 1'b1;
    @(negedge clock);
    user_ready = 1'b0;
    chk("rst.stale_ready", if_rr.ch_ready_o, 0);
    ch_valid = 3'b101;
    @(negedge clock);
    chk("rst.rr_ptr_restart", if_rr.grant_o, 3'b001);
    serve({16{32'h0BAD_F00D}}, 2'b10, 1);
    ch_valid = '0;
    chk("rst.ch0_ready", if_rr.ch_ready_o, 3'b001);
    @(negedge clock);

    // completion pulse held into the response cycle
    ch_valid = 3'b001;
    @(negedge clock);
    ch_valid = '0;
    serve({16{32'h1234_5678}}, 2'b00, 2);
    chk("resp_spurious.ch_ready", if_rr.ch_ready_o, 0);
    chk("resp_spurious.grant", if_rr.grant_o, 0);
    repeat (3) @(negedge clock);
    chk("resp_spurious.idle", if_rr.user_valid_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
